// File: rtl/rand_range.sv
// rand_range: rejection-sampling bounded random generator.
// Draws masked bytes until one fits [0, max]; after a retry budget, halves the last draw instead.
module rand_range #(
  parameter int RETRY_LIMIT = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] random,
  input  logic       req,
  input  logic [7:0] max,
  input  logic       ready,
  output logic       busy,
  output logic       valid,
  output logic [7:0] value,
  output logic [3:0] rejects,
  output logic       fallback
);
  typedef enum logic [1:0] {IDLE, SAMPLE, DONE} state_t;
  state_t state, state_n;
  logic [7:0] max_q, max_n, mask, mask_n, val, val_n, cand, s1, s2, s3;
  logic [3:0] rej, rej_n;
  logic fb, fb_n, capture;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      max_q <= '0;
      mask  <= '0;
      val   <= '0;
      rej   <= '0;
      fb    <= 1'b0;
    end else begin
      state <= state_n;
      max_q <= max_n;
      mask  <= mask_n;
      val   <= val_n;
      rej   <= rej_n;
      fb    <= fb_n;
    end
  end
  // Bit-smearing max yields the smallest all-ones mask covering it
  always_comb begin
    s1 = max | (max >> 1);
    s2 = s1 | (s1 >> 2);
    s3 = s2 | (s2 >> 4);
    cand = random & mask;
    capture = req && (state == IDLE || (state == DONE && ready));
    state_n = state;
    max_n = max_q;
    mask_n = mask;
    val_n = val;
    rej_n = rej;
    fb_n = fb;
    if (capture) begin
      state_n = SAMPLE;
      max_n = max;
      mask_n = s3;
      rej_n = '0;
      fb_n = 1'b0;
    end else if (state == DONE && ready) begin
      state_n = IDLE;
    end else if (state == SAMPLE) begin
      if (cand <= max_q) begin
        val_n = cand;
        fb_n = 1'b0;
        state_n = DONE;
      end else begin
        rej_n = (rej == 4'hF) ? rej : rej + 4'd1;
        if (rej == 4'(RETRY_LIMIT - 1)) begin
          val_n = cand >> 1;
          fb_n = 1'b1;
          state_n = DONE;
        end
      end
    end
  end
  assign busy = state != IDLE;
  assign valid = state == DONE;
  assign value = val;
  assign rejects = rej;
  assign fallback = fb && state == DONE;
endmodule

// File: tb/tb_rand_range.sv
// tb_rand_range: directed vector table plus hand sequences and an invariant sweep for rand_range.
module tb_rand_range;
  logic clk = 1'b0, rst_n = 1'b0, req = 1'b0, ready = 1'b0;
  logic [7:0] random = '0, max = '0;
  logic busy, valid, fallback;
  logic [7:0] value;
  logic [3:0] rejects;
  int n = 0, err = 0;

  rand_range #(.RETRY_LIMIT(7)) dut (
    .clk(clk), .rst_n(rst_n), .random(random), .req(req), .max(max), .ready(ready),
    .busy(busy), .valid(valid), .value(value), .rejects(rejects), .fallback(fallback)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  m;
    logic [63:0] seq;
    logic [7:0]  v;
    logic [3:0]  r;
    logic        f;
    int          c;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string nm, input logic ok, input int act, input int exp);
    n++;
    if (!ok) begin
      err++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic eq(input string nm, input int act, input int exp);
    chk(nm, act == exp, act, exp);
  endtask

  // Issues one request; seq byte k is driven for sample cycle k (last byte held)
  task automatic run_req(input logic [7:0] m, input logic [63:0] seq, output int cyc);
    @(negedge clk);
    req = 1'b1;
    max = m;
    random = 8'h00;
    @(negedge clk);
    req = 1'b0;
    max = ~m;
    cyc = 0;
    while (!valid && cyc < 20) begin
      random = seq[8*(cyc > 7 ? 7 : cyc) +: 8];
      @(negedge clk);
      cyc++;
    end
    if (!valid) eq("timeout", cyc, -1);
  endtask

  task automatic release_done();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    eq("release_valid", int'(valid), 0);
    eq("release_busy", int'(busy), 0);
  endtask

  initial begin
    int cyc;
    logic [7:0] lfsr, mx, held;
    vecs[0] = '{8'd9,   64'h3737373737373737, 8'd7,    4'd0, 1'b0, 1};
    vecs[1] = '{8'd9,   64'h0505050505050E0C, 8'd5,    4'd2, 1'b0, 3};
    vecs[2] = '{8'd9,   64'h0F0F0F0F0F0F0F0F, 8'd7,    4'd7, 1'b1, 7};
    vecs[3] = '{8'd255, 64'hA5A5A5A5A5A5A5A5, 8'hA5,   4'd0, 1'b0, 1};
    vecs[4] = '{8'd0,   64'hFFFFFFFFFFFFFFFF, 8'd0,    4'd0, 1'b0, 1};
    vecs[5] = '{8'd8,   64'h2828282828282819, 8'd8,    4'd1, 1'b0, 2};
    vecs[6] = '{8'd7,   64'hFFFFFFFFFFFFFFFF, 8'd7,    4'd0, 1'b0, 1};
    vecs[7] = '{8'd200, 64'hC8C8C8C8C8C8C9FF, 8'd200,  4'd2, 1'b0, 3};
    vecs[8] = '{8'd2,   64'h0303030303030303, 8'd1,    4'd7, 1'b1, 7};
    vecs[9] = '{8'd128, 64'h0000000000000081, 8'd0,    4'd1, 1'b0, 2};

    #1;
    eq("rst_busy", int'(busy), 0);
    eq("rst_valid", int'(valid), 0);
    eq("rst_value", int'(value), 0);
    eq("rst_rejects", int'(rejects), 0);
    eq("rst_fallback", int'(fallback), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_req(vecs[i].m, vecs[i].seq, cyc);
      eq($sformatf("v%0d_value", i), int'(value), int'(vecs[i].v));
      eq($sformatf("v%0d_rejects", i), int'(rejects), int'(vecs[i].r));
      eq($sformatf("v%0d_fallback", i), int'(fallback), int'(vecs[i].f));
      eq($sformatf("v%0d_cycles", i), cyc, vecs[i].c);
      release_done();
    end

    // Held result under a stalled consumer, then back-to-back request with max=0
    run_req(8'd9, 64'h3737373737373737, cyc);
    for (int i = 0; i < 5; i++) begin
      random = 8'($urandom);
      max = 8'($urandom);
      @(negedge clk);
      eq("hold_valid", int'(valid), 1);
      eq("hold_value", int'(value), 7);
      eq("hold_rejects", int'(rejects), 0);
      eq("hold_fallback", int'(fallback), 0);
    end
    ready = 1'b1;
    req = 1'b1;
    max = 8'd0;
    @(negedge clk);
    ready = 1'b0;
    req = 1'b0;
    random = 8'h5A;
    eq("b2b_gap_valid", int'(valid), 0);
    eq("b2b_gap_busy", int'(busy), 1);
    @(negedge clk);
    eq("b2b_valid", int'(valid), 1);
    eq("b2b_value", int'(value), 0);
    eq("b2b_rejects", int'(rejects), 0);
    release_done();

    // Asynchronous reset in the middle of sampling
    run_req(8'd255, 64'h3C3C3C3C3C3C3C3C, cyc);
    release_done();
    @(negedge clk);
    req = 1'b1;
    max = 8'd200;
    @(negedge clk);
    req = 1'b0;
    random = 8'hFF;
    @(negedge clk);
    @(negedge clk);
    eq("pre_rst_rejects", int'(rejects), 2);
    #2 rst_n = 1'b0;
    #1;
    eq("arst_busy", int'(busy), 0);
    eq("arst_valid", int'(valid), 0);
    eq("arst_value", int'(value), 0);
    eq("arst_rejects", int'(rejects), 0);
    eq("arst_fallback", int'(fallback), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_req(8'd255, 64'hA5A5A5A5A5A5A5A5, cyc);
    eq("post_rst_value", int'(value), 8'hA5);
    eq("post_rst_rejects", int'(rejects), 0);
    eq("post_rst_cycles", cyc, 1);
    release_done();

    // Invariant sweep driven by an LFSR random source
    lfsr = 8'hB7;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      req = 1'b1;
      mx = 8'($urandom);
      max = mx;
      @(negedge clk);
      req = 1'b0;
      max = 8'($urandom);
      cyc = 0;
      while (!valid && cyc < 20) begin
        random = lfsr;
        lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        ready = 1'($urandom);
        @(negedge clk);
        cyc++;
      end
      ready = 1'b0;
      chk("sweep_valid", valid, int'(valid), 1);
      chk("sweep_value_le_max", value <= mx, int'(value), int'(mx));
      chk("sweep_rejects_le_limit", rejects <= 4'd7, int'(rejects), 7);
      chk("sweep_fallback_rejects", !fallback || rejects == 4'd7, int'(rejects), 7);
      held = value;
      for (int h = $urandom_range(0, 3); h > 0; h--) begin
        @(negedge clk);
        chk("sweep_hold_valid", valid, int'(valid), 1);
        eq("sweep_hold_value", int'(value), int'(held));
      end
      release_done();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n, err);
    $finish;
  end
endmodule
